// File: rtl/irq_gateway_pkg.sv
// Shared types and helpers for the interrupt gateway.
package irq_gateway_pkg;

    // Request state of one interrupt line.
    typedef enum logic [1:0] {
        LINE_IDLE       = 2'd0,
        LINE_PENDING    = 2'd1,
        LINE_IN_SERVICE = 2'd2
    } line_state_e;

    // Width of a line index: max(1, clog2(n)).
    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-bit multi-flop synchroniser for one raw asynchronous request line.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/irq_gateway.sv
// Per-line interrupt gateway: synchronise, qualify level/edge, track
// pending/in-service per line, and answer claim/complete from the trap handler.
//
// state            | meaning
// -----------------+-------------------------------------------------------
// LINE_IDLE        | no request outstanding; a trigger makes the line pending
// LINE_PENDING     | request waiting; visible on extIrq when enabled
// LINE_IN_SERVICE  | claimed by the handler; edge triggers set the again bit
module irq_gateway
    import irq_gateway_pkg::*;
#(
    parameter  int EXT_IRQ_COUNT = 4,
    parameter  int SYNC_STAGES   = 2,
    localparam int IDW           = calc_idw(EXT_IRQ_COUNT)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [EXT_IRQ_COUNT-1:0] irqIn,
    input  logic [EXT_IRQ_COUNT-1:0] edgeMode,
    input  logic [EXT_IRQ_COUNT-1:0] irqEnable,
    input  logic                     claimReq,
    output logic                     claimAck,
    output logic [IDW-1:0]           claimId,
    output logic                     claimEmpty,
    input  logic                     completeReq,
    input  logic [IDW-1:0]           completeId,
    output logic [EXT_IRQ_COUNT-1:0] extIrq
);

    logic [EXT_IRQ_COUNT-1:0] sync_q;
    logic [EXT_IRQ_COUNT-1:0] hist_q;
    logic [EXT_IRQ_COUNT-1:0] trig;

    line_state_e              state_q [EXT_IRQ_COUNT];
    line_state_e              state_d [EXT_IRQ_COUNT];
    logic [EXT_IRQ_COUNT-1:0] again_q;
    logic [EXT_IRQ_COUNT-1:0] again_d;

    logic [EXT_IRQ_COUNT-1:0] pending;
    logic [EXT_IRQ_COUNT-1:0] in_service;
    logic [EXT_IRQ_COUNT-1:0] complete_hit;
    logic [EXT_IRQ_COUNT-1:0] cand;
    logic [EXT_IRQ_COUNT-1:0] claim_hit;
    logic [IDW-1:0]           sel_id;
    logic                     any_cand;

    for (genvar g = 0; g < EXT_IRQ_COUNT; g++) begin : g_line_sync
        irq_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rstn (rstn),
            .d    (irqIn[g]),
            .q    (sync_q[g])
        );
    end

    // History of the synchronised value, used only for rising-edge detection.
    // Resetting to 0 makes a line held high through reset count as one edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q <= '0;
        end else begin
            hist_q <= sync_q;
        end
    end

    // Level lines trigger while high; edge lines only on a 0->1 transition.
    assign trig = sync_q & (~edgeMode | ~hist_q);

    // Decode state flags, matching complete, claim candidates and priority winner.
    always_comb begin
        pending      = '0;
        in_service   = '0;
        complete_hit = '0;
        for (int i = 0; i < EXT_IRQ_COUNT; i++) begin
            pending[i]      = (state_q[i] == LINE_PENDING);
            in_service[i]   = (state_q[i] == LINE_IN_SERVICE);
            complete_hit[i] = completeReq && (completeId == IDW'(i)) && in_service[i];
        end

        // A line being completed this cycle is never offered to a claim.
        cand     = pending & irqEnable & ~complete_hit;
        any_cand = |cand;

        sel_id = '0;
        for (int i = EXT_IRQ_COUNT - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_id = IDW'(i);
            end
        end

        claim_hit = '0;
        for (int i = 0; i < EXT_IRQ_COUNT; i++) begin
            claim_hit[i] = claimReq && cand[i] && (sel_id == IDW'(i));
        end
    end

    // Per-line next state and sticky again bit.
    always_comb begin
        for (int i = 0; i < EXT_IRQ_COUNT; i++) begin
            state_d[i] = state_q[i];
            again_d[i] = again_q[i];
            case (state_q[i])
                LINE_IDLE: begin
                    if (trig[i]) begin
                        state_d[i] = LINE_PENDING;
                    end
                end
                LINE_PENDING: begin
                    if (claim_hit[i]) begin
                        state_d[i] = LINE_IN_SERVICE;
                    end
                end
                LINE_IN_SERVICE: begin
                    if (complete_hit[i]) begin
                        // An edge arriving on the completing cycle is kept, not dropped.
                        if (again_q[i] || (edgeMode[i] && trig[i])) begin
                            state_d[i] = LINE_PENDING;
                        end else begin
                            state_d[i] = LINE_IDLE;
                        end
                        again_d[i] = 1'b0;
                    end else if (edgeMode[i] && trig[i]) begin
                        again_d[i] = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = LINE_IDLE;
                    again_d[i] = 1'b0;
                end
            endcase
        end
    end

    // Line state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < EXT_IRQ_COUNT; i++) begin
                state_q[i] <= LINE_IDLE;
            end
            again_q <= '0;
        end else begin
            for (int i = 0; i < EXT_IRQ_COUNT; i++) begin
                state_q[i] <= state_d[i];
            end
            again_q <= again_d;
        end
    end

    // Registered one-cycle claim response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            claimAck   <= 1'b0;
            claimId    <= '0;
            claimEmpty <= 1'b0;
        end else begin
            claimAck   <= claimReq;
            claimId    <= (claimReq && any_cand) ? sel_id : '0;
            claimEmpty <= claimReq && !any_cand;
        end
    end

    assign extIrq = pending & irqEnable;

endmodule

// File: doc/irq_gateway.md
# irq_gateway

Per-line interrupt gateway sitting directly upstream of the interrupt controller: it synchronises raw asynchronous interrupt lines, qualifies them as level- or edge-triggered, holds each request in a pending/in-service state machine, and drives the masked pending vector onto the controller's `extIrq` input. The CPU trap handler claims the highest-priority pending line and signals completion through a claim/complete handshake, so a line cannot re-request until its handler has finished.

## Interface
- `EXT_IRQ_COUNT`, 4, number of interrupt lines; must match the downstream controller.
- `SYNC_STAGES`, 2, synchroniser depth per line, minimum 2.
- `IDW`, derived, max(1, clog2(`EXT_IRQ_COUNT`)); not overridable.

- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `irqIn`  in  `EXT_IRQ_COUNT`  raw asynchronous request lines, active high.
- `edgeMode`  in  `EXT_IRQ_COUNT`  per line: 1 = rising-edge triggered, 0 = level-high triggered; quasi-static.
- `irqEnable`  in  `EXT_IRQ_COUNT`  per-line mask; 0 hides the line from `extIrq` and from claim.
- `claimReq`  in  1  single-cycle pulse: claim the highest-priority pending line.
- `claimAck`  out  1  one-cycle pulse answering `claimReq`.
- `claimId`  out  `IDW`  claimed line index; valid while `claimAck`=1.
- `claimEmpty`  out  1  with `claimAck`: 1 = nothing claimable, `claimId`=0.
- `completeReq`  in  1  single-cycle pulse: handler for `completeId` finished.
- `completeId`  in  `IDW`  line being completed.
- `extIrq`  out  `EXT_IRQ_COUNT`  pending & enabled; feeds the interrupt controller.

## Operation
- Per line: `SYNC_STAGES`-flop synchroniser, plus one history flop of the synchronised value for edge detection.
- Trigger: level mode = synchronised value 1; edge mode = synchronised 1 and history 0.
- Per-line states IDLE, PENDING, IN_SERVICE, plus a sticky `again` bit.
  - IDLE -> PENDING on trigger (enable ignored; masking only affects visibility).
  - PENDING -> IN_SERVICE when claimed; further triggers absorbed, no counting.
  - IN_SERVICE: edge trigger sets `again`; level triggers ignored.
  - IN_SERVICE -> PENDING on matching complete if `again`=1 (clears `again`), else -> IDLE.
- Claim: among lines PENDING and enabled, lowest index wins. No candidate: `claimEmpty`=1, `claimId`=0, no state change.
- Complete with id not IN_SERVICE or id >= `EXT_IRQ_COUNT`: ignored.
- `extIrq[i]` = (state PENDING) & `irqEnable[i]`, combinational from state registers.
- `claimReq` while `claimAck` is high: treated as a new request.

## Timing
- Reset (async assert, sync-safe deassert upstream): sync/history flops 0, all lines IDLE, `again`=0, `extIrq`=0, `claimAck`=0, `claimId`=0, `claimEmpty`=0.
- `irqIn` rise sampled at edge k -> PENDING (and `extIrq`) after edge k+`SYNC_STAGES`; latency `SYNC_STAGES`+1 cycles.
- Edge line held high across reset release counts as one rising edge.
- `claimReq` at edge k -> `claimAck`/`claimId`/`claimEmpty` valid after edge k, for one cycle; line is IN_SERVICE from the same edge; `extIrq` bit drops at that edge.
- `completeReq` at edge k -> new state after edge k; level line still high re-pends at edge k+1.
- Simultaneous claim and complete: both applied; the completing line is not a claim candidate in that cycle.
- Trigger and claim in same cycle on an IDLE line: line becomes PENDING, not claimed.
- `irqEnable` change takes effect on `extIrq` combinationally and on the next claim.

## Structure
- Shared package: line state enum (IDLE, PENDING, IN_SERVICE), `IDW` computation function.
- Sub-module `irq_sync`: parameterised `SYNC_STAGES` single-bit synchroniser with async active-low reset; instantiated per line.
- Priority selection and claim/complete decoding stay in `irq_gateway`.

## Test plan
- Level line 2 high, enabled, `SYNC_STAGES`=2 -> `extIrq`=4'b0100 three cycles later; claim -> `claimId`=2, `claimEmpty`=0, `extIrq`=0; complete 2 while still high -> `extIrq`=4'b0100 one cycle later.
- Edge lines 1 and 3 pulse together -> `extIrq`=4'b1010; claim -> id 1; claim -> id 3; claim -> `claimEmpty`=1, `claimId`=0.
- Edge line 0 pulses while IN_SERVICE -> `extIrq` stays 0; complete 0 -> `extIrq`=4'b0001 immediately after.
- Line 1 pending with `irqEnable[1]`=0 -> `extIrq`=0, claim returns `claimEmpty`=1; enable -> `extIrq`=4'b0010, claim returns id 1.
- Complete id 3 while line 3 IDLE, and complete id 2 with claim in same cycle -> line 3 unaffected; claim never returns id 2 that cycle.
- `rstn` asserted mid-service with lines 0 and 2 pending/in service -> all outputs 0 asynchronously; after release, level line still high re-pends after 3 cycles.
